// File: rtl/snitch_vfpr_arbiter.sv
// rtl/snitch_vfpr_arbiter.sv - round-robin arbiter sharing the vfpr request port
// Locks onto a stalled grant and steers in-order responses back through an ID FIFO.
package snitch_vfpr_arbiter_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        user;
  } tcdm_req_chan_t;

  typedef struct packed {
    logic           q_valid;
    tcdm_req_chan_t q;
  } tcdm_req_t;

  typedef struct packed {
    logic [63:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    logic           q_ready;
    logic           p_valid;
    tcdm_rsp_chan_t p;
  } tcdm_rsp_t;
endpackage

module snitch_vfpr_arbiter #(
  parameter int unsigned NumInp         = 3,
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          StrayRspAssert = 1'b1,
  parameter type         tcdm_req_t     = snitch_vfpr_arbiter_pkg::tcdm_req_t,
  parameter type         tcdm_rsp_t     = snitch_vfpr_arbiter_pkg::tcdm_rsp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  tcdm_req_t in_req_i [NumInp-1:0],
  output tcdm_rsp_t in_rsp_o [NumInp-1:0],
  output tcdm_req_t out_req_o,
  input  tcdm_rsp_t out_rsp_i,
  output logic      busy_o
);

  localparam int unsigned IdxW = (NumInp > 1) ? $clog2(NumInp) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumInp - 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(MaxOutstanding);

  logic [IdxW-1:0] rr_q, lock_idx_q, sel, cand, head;
  logic            lock_q, any_sel, can_issue, req_valid, hs, pop;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;

  // A stalled request keeps its grant so the downstream request stays stable.
  always_comb begin
    sel     = rr_q;
    cand    = '0;
    any_sel = 1'b0;
    if (lock_q) begin
      sel     = lock_idx_q;
      any_sel = in_req_i[lock_idx_q].q_valid;
    end else begin
      for (int k = 0; k < int'(NumInp); k++) begin
        cand = IdxW'((int'(rr_q) + k) % int'(NumInp));
        if (!any_sel && in_req_i[cand].q_valid) begin
          sel     = cand;
          any_sel = 1'b1;
        end
      end
    end
  end

  assign can_issue = (cnt_q != FullCnt) | out_rsp_i.p_valid;
  assign req_valid = any_sel & can_issue;
  assign hs        = req_valid & out_rsp_i.q_ready;
  assign pop       = out_rsp_i.p_valid & (cnt_q != '0);
  assign head      = fifo_q[rd_ptr_q];
  assign busy_o    = (cnt_q != '0);

  always_comb begin
    out_req_o = '0;
    if (rst_ni && any_sel) begin
      out_req_o.q       = in_req_i[sel].q;
      out_req_o.q_valid = can_issue;
    end
    for (int i = 0; i < int'(NumInp); i++) begin
      in_rsp_o[i] = '0;
      if (rst_ni) begin
        in_rsp_o[i].p       = out_rsp_i.p;
        in_rsp_o[i].q_ready = out_rsp_i.q_ready & req_valid & (sel == IdxW'(i));
        in_rsp_o[i].p_valid = pop & (head == IdxW'(i));
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < int'(MaxOutstanding); i++) fifo_q[i] <= '0;
    end else begin
      if (hs) begin
        rr_q   <= (sel == LastIdx) ? '0 : sel + 1'b1;
        lock_q <= 1'b0;
      end else if (req_valid) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
      if (hs) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      if (hs && !pop) cnt_q <= cnt_q + 1'b1;
      else if (pop && !hs) cnt_q <= cnt_q - 1'b1;
    end
  end

  lock_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> in_req_i[lock_idx_q].q_valid)
    else $error("requester dropped q_valid while its grant was stalled");

  if (StrayRspAssert) begin : g_stray_chk
    stray_rsp_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(out_rsp_i.p_valid && cnt_q == '0))
      else $error("response received with no outstanding request");
  end

endmodule

// File: tb/tb_snitch_vfpr_arbiter.sv
// tb/tb_snitch_vfpr_arbiter.sv - self-checking bench for snitch_vfpr_arbiter
// Queue-based reference model checked every cycle, plus directed literal expectations.
module tb_snitch_vfpr_arbiter;
  import snitch_vfpr_arbiter_pkg::*;

  localparam int N    = 3;
  localparam int MAXO = 4;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  tcdm_req_t in_req [N-1:0];
  tcdm_rsp_t in_rsp [N-1:0];
  tcdm_req_t out_req;
  tcdm_rsp_t out_rsp;
  logic      busy;

  always #5 clk = ~clk;

  snitch_vfpr_arbiter #(
    .NumInp(N), .MaxOutstanding(MAXO), .StrayRspAssert(1'b0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_req_i(in_req), .in_rsp_o(in_rsp),
    .out_req_o(out_req), .out_rsp_i(out_rsp), .busy_o(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int m_rr = 0, m_lock = 0, m_lock_idx = 0;
  int m_fifo[$];
  int grants[$];
  int rsps[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Who the rules say should own the port right now.
  function automatic void m_pick(output int s, output bit any);
    s = 0;
    any = 1'b0;
    if (m_lock != 0) begin
      s = m_lock_idx;
      any = in_req[s].q_valid;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (!any && in_req[j].q_valid) begin
          s = j;
          any = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [127:0] tail(input int q[$], input int n);
    logic [127:0] r;
    r = '0;
    for (int k = q.size() - n; k < q.size(); k++)
      r = (r << 4) | ((k >= 0) ? 128'(q[k]) : 128'hF);
    return r;
  endfunction

  always @(negedge clk) begin : compare
    int s;
    bit any, can;
    tcdm_req_t er;
    tcdm_rsp_t ep;
    s = 0; any = 1'b0; can = 1'b0; er = '0;
    if (rst_n) begin
      m_pick(s, any);
      can = (m_fifo.size() != MAXO) || out_rsp.p_valid;
      if (any) begin
        er.q = in_req[s].q;
        er.q_valid = can;
      end
    end
    chk("out_req", out_req, er);
    for (int i = 0; i < N; i++) begin
      ep = '0;
      if (rst_n) begin
        ep.p = out_rsp.p;
        ep.q_ready = out_rsp.q_ready && can && any && (s == i);
        ep.p_valid = out_rsp.p_valid && (m_fifo.size() > 0) && (m_fifo[0] == i);
      end
      chk($sformatf("in_rsp[%0d]", i), in_rsp[i], ep);
    end
    chk("busy", busy, m_fifo.size() != 0);
  end

  always @(posedge clk or negedge rst_n) begin : model
    int s;
    bit any, can, v;
    if (!rst_n) begin
      m_rr = 0; m_lock = 0; m_lock_idx = 0;
      m_fifo.delete();
    end else begin
      m_pick(s, any);
      can = (m_fifo.size() != MAXO) || out_rsp.p_valid;
      v = any && can;
      if (out_rsp.p_valid && m_fifo.size() > 0) rsps.push_back(m_fifo.pop_front());
      if (v && out_rsp.q_ready) begin
        m_fifo.push_back(s);
        grants.push_back(s);
        m_rr = (s + 1) % N;
        m_lock = 0;
      end else if (v) begin
        m_lock = 1;
        m_lock_idx = s;
      end
    end
  end

  task automatic drive(input bit [2:0] v, input bit qr, input bit pv, input logic [63:0] pd);
    for (int i = 0; i < N; i++) in_req[i].q_valid = v[i];
    out_rsp.q_ready = qr;
    out_rsp.p_valid = pv;
    out_rsp.p.data = pd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      in_req[i] = '0;
      in_req[i].q.addr = 32'(32'h100 * i);
      in_req[i].q.write = 1'b1;
      in_req[i].q.data = {32'hDA7A0000 | 32'(i), 32'(32'h100 * i)};
      in_req[i].q.strb = 8'hFF;
    end
    out_rsp = '0;
    drive(3'b111, 1, 1, 64'h55);
    tick(); tick();
    chk("rst_out_req", out_req, '0);
    chk("rst_in_rsp1", in_rsp[1], '0);
    chk("rst_busy", busy, 0);
    drive(3'b000, 1, 0, 0);
    rst_n = 1'b1;

    // single requester, no stall
    grants.delete(); rsps.delete();
    in_req[1].q.addr = 32'h10;
    drive(3'b010, 1, 0, 0);
    chk("t1_addr0", out_req.q.addr, 32'h10);
    chk("t1_ready1", in_rsp[1].q_ready, 1);
    tick();
    in_req[1].q.addr = 32'h18;
    drive(3'b010, 1, 1, 64'h111);
    chk("t1_addr1", out_req.q.addr, 32'h18);
    chk("t1_pv1", in_rsp[1].p_valid, 1);
    chk("t1_pv0", in_rsp[0].p_valid, 0);
    tick();
    drive(3'b000, 1, 1, 64'h222);
    chk("t1_data", in_rsp[1].p.data, 64'h222);
    tick();
    drive(3'b000, 1, 0, 0);
    chk("t1_busy", busy, 0);
    chk("t1_grants", tail(grants, 2), 'h11);
    chk("t1_rsps", tail(rsps, 2), 'h11);

    // round-robin over all requesters from rr = 0
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    grants.delete(); rsps.delete();
    drive(3'b111, 1, 0, 0); tick();
    for (int c = 0; c < 5; c++) begin drive(3'b111, 1, 1, 64'(c)); tick(); end
    drive(3'b000, 1, 1, 64'h9); tick();
    chk("t2_order", tail(grants, 6), 'h012012);
    drive(3'b110, 1, 0, 0); tick();
    drive(3'b110, 1, 1, 64'h1); tick();
    drive(3'b000, 1, 1, 64'h2); tick();
    chk("t2_pair", tail(grants, 2), 'h12);

    // back-pressure lock on input 2
    drive(3'b100, 0, 0, 0); tick();
    drive(3'b101, 0, 0, 0);
    chk("t3_held", out_req.q.addr, 32'h200);
    chk("t3_no_rdy0", in_rsp[0].q_ready, 0);
    tick();
    drive(3'b101, 0, 0, 0); tick();
    drive(3'b101, 1, 0, 0);
    chk("t3_rdy2", in_rsp[2].q_ready, 1);
    tick();
    drive(3'b001, 1, 1, 64'h3);
    chk("t3_rdy0", in_rsp[0].q_ready, 1);
    tick();
    drive(3'b000, 1, 1, 64'h4); tick();
    chk("t3_order", tail(grants, 2), 'h20);

    // FIFO full, then grant alongside a retiring response
    grants.delete();
    for (int c = 0; c < 4; c++) begin drive(3'b001, 1, 0, 0); tick(); end
    drive(3'b001, 1, 0, 0);
    chk("t4_full_rdy", in_rsp[0].q_ready, 0);
    chk("t4_full_valid", out_req.q_valid, 0);
    chk("t4_model_cnt", m_fifo.size(), 4);
    tick();
    drive(3'b001, 1, 1, 64'h5);
    chk("t4_pass_rdy", in_rsp[0].q_ready, 1);
    tick();
    drive(3'b001, 1, 0, 0);
    chk("t4_still_full", in_rsp[0].q_ready, 0);
    tick();
    for (int c = 0; c < 4; c++) begin drive(3'b000, 1, 1, 64'(c)); tick(); end
    drive(3'b000, 1, 0, 0);
    chk("t4_busy", busy, 0);
    chk("t4_grants", grants.size(), 5);

    // responses steered by issue order
    rsps.delete();
    drive(3'b001, 1, 0, 0); tick();
    drive(3'b100, 1, 0, 0); tick();
    drive(3'b010, 1, 0, 0); tick();
    drive(3'b000, 1, 1, 64'hA);
    chk("t5_pv0", in_rsp[0].p_valid, 1);
    chk("t5_pv2_idle", in_rsp[2].p_valid, 0);
    chk("t5_dA", in_rsp[0].p.data, 64'hA);
    tick();
    drive(3'b000, 1, 1, 64'hB);
    chk("t5_pv2", in_rsp[2].p_valid, 1);
    tick();
    drive(3'b000, 1, 1, 64'hC);
    chk("t5_pv1", in_rsp[1].p_valid, 1);
    chk("t5_dC", in_rsp[1].p.data, 64'hC);
    tick();
    chk("t5_rsps", tail(rsps, 3), 'h021);

    // reset with three outstanding
    for (int c = 0; c < 3; c++) begin drive(3'b111, 1, 0, 0); tick(); end
    chk("t6_busy_pre", busy, 1);
    drive(3'b111, 1, 1, 64'h66);
    rst_n = 1'b0;
    #1;
    chk("t6_out_req", out_req, '0);
    for (int i = 0; i < N; i++) chk($sformatf("t6_in_rsp%0d", i), in_rsp[i], '0);
    chk("t6_busy_rst", busy, 0);
    tick(); tick();
    drive(3'b000, 0, 0, 0);
    rst_n = 1'b1;
    drive(3'b000, 1, 1, 64'h77);
    chk("t6_busy_post", busy, 0);
    for (int i = 0; i < N; i++) chk($sformatf("t6_stray%0d", i), in_rsp[i].p_valid, 0);
    tick();
    drive(3'b000, 1, 0, 0); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
